// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
//
// Loads the fabric configuration scan chain. The chain is made of the 4-bit
// selector registers of the routing muxes. Configuration words arrive on a
// valid/ready stream. Each word is shifted onto the chain LSB-first. Once
// CHAIN_LEN bits have been shifted, a one-cycle cfg_latch strobe commits the
// chain into the mux shadow registers, so the muxes never see a partial load.
// Unused upper bits of the final word are dropped and never shifted.
//
// Optional feature (macro CFG_CHECK_EN): after the payload words, one extra
// checksum word is accepted. This word is the XOR of all payload words and is
// not shifted. On a mismatch the load ends in DONE with error=1, done=0 and no
// commit. Without the macro, error is tied low and no checksum logic is built.
//
// Parameters:
//   CHAIN_LEN  total config bits in the chain (>=1)
//   WORD_W     width of one input config word (>=2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a load (honoured in IDLE or DONE only)
//   abort      synchronous cancel back to IDLE, no commit
//   s_valid    input word valid
//   s_ready    word accepted this cycle (FETCH and no abort)
//   s_data     config word, bit 0 shifted first
//   cfg_en     chain shift enable
//   cfg_bit    serial chain data, meaningful when cfg_en=1
//   cfg_latch  one-cycle commit pulse to the mux selector shadow regs
//   busy       load in progress (FETCH/SHIFT/LATCH)
//   done       last load committed, held until the next start
//   error      checksum failure, held until the next start
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cfg_en,
    output logic              cfg_bit,
    output logic              cfg_latch,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int TB_W      = $clog2(CHAIN_LEN + 1);
    localparam int BW_W      = $clog2(WORD_W + 1);
    // Word counter must reach NWORDS (the checksum slot when checking is on).
    localparam int WC_W      = $clog2(NWORDS + 2);

    localparam logic [TB_W-1:0] TOTAL_LIM = TB_W'(CHAIN_LEN);
    localparam logic [BW_W-1:0] FULL_LIM  = BW_W'(WORD_W);
    localparam logic [BW_W-1:0] LAST_LIM  = BW_W'(LAST_BITS);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

`ifdef CFG_CHECK_EN
    localparam logic [WC_W-1:0] CHECK_WORD = WC_W'(NWORDS);
    // With checking, the last payload bit leads back to FETCH for the checksum.
    localparam state_t AFTER_PAYLOAD = S_FETCH;
`else
    localparam state_t AFTER_PAYLOAD = S_LATCH;
`endif

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] sreg_reg, sreg_next;
    logic [BW_W-1:0]   bit_cnt_reg, bit_cnt_next, bit_cnt_inc, word_limit;
    logic [TB_W-1:0]   total_reg, total_next, total_inc;
    logic [WC_W-1:0]   word_cnt_reg, word_cnt_next;
    logic              done_reg, done_next;
    logic              handshake;
`ifdef CFG_CHECK_EN
    logic [WORD_W-1:0] xsum_reg, xsum_next;
    logic              error_reg, error_next;
`endif

    // Outputs decode straight from state so an asynchronous reset clears
    // them immediately. abort masks s_ready so the offered word is not taken.
    assign s_ready   = (state_reg == S_FETCH) && !abort;
    assign handshake = s_valid && s_ready;
    assign cfg_en    = (state_reg == S_SHIFT);
    assign cfg_bit   = cfg_en && sreg_reg[0];
    assign cfg_latch = (state_reg == S_LATCH);
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_SHIFT) ||
                       (state_reg == S_LATCH);
    assign done      = done_reg;
`ifdef CFG_CHECK_EN
    assign error     = error_reg;
`else
    assign error     = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        sreg_next     = sreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        total_next    = total_reg;
        word_cnt_next = word_cnt_reg;
        done_next     = done_reg;
`ifdef CFG_CHECK_EN
        xsum_next     = xsum_reg;
        error_next    = error_reg;
`endif
        bit_cnt_inc   = bit_cnt_reg + 1'b1;
        total_inc     = total_reg + 1'b1;
        word_limit    = (word_cnt_reg == LAST_WORD) ? LAST_LIM : FULL_LIM;

        unique case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_FETCH;
                    bit_cnt_next  = '0;
                    total_next    = '0;
                    word_cnt_next = '0;
                    done_next     = 1'b0;
`ifdef CFG_CHECK_EN
                    xsum_next     = '0;
                    error_next    = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (handshake) begin
`ifdef CFG_CHECK_EN
                    if (word_cnt_reg == CHECK_WORD) begin
                        if (s_data == xsum_reg) begin
                            state_next = S_LATCH;
                        end else begin
                            state_next = S_DONE;
                            error_next = 1'b1;
                        end
                    end else begin
                        sreg_next    = s_data;
                        xsum_next    = xsum_reg ^ s_data;
                        bit_cnt_next = '0;
                        state_next   = S_SHIFT;
                    end
`else
                    sreg_next    = s_data;
                    bit_cnt_next = '0;
                    state_next   = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                sreg_next    = sreg_reg >> 1;
                bit_cnt_next = bit_cnt_inc;
                total_next   = total_inc;
                if (bit_cnt_inc == word_limit) begin
                    word_cnt_next = word_cnt_reg + 1'b1;
                    state_next    = (total_inc == TOTAL_LIM) ? AFTER_PAYLOAD : S_FETCH;
                end
            end
            S_LATCH: begin
                done_next  = 1'b1;
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase

        // Cancel wins over start and over any handshake in the same cycle.
        if (abort && (state_reg != S_IDLE)) begin
            state_next    = S_IDLE;
            sreg_next     = '0;
            bit_cnt_next  = '0;
            total_next    = '0;
            word_cnt_next = '0;
            done_next     = 1'b0;
`ifdef CFG_CHECK_EN
            xsum_next     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            sreg_reg     <= '0;
            bit_cnt_reg  <= '0;
            total_reg    <= '0;
            word_cnt_reg <= '0;
            done_reg     <= 1'b0;
`ifdef CFG_CHECK_EN
            xsum_reg     <= '0;
            error_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            sreg_reg     <= sreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            total_reg    <= total_next;
            word_cnt_reg <= word_cnt_next;
            done_reg     <= done_next;
`ifdef CFG_CHECK_EN
            xsum_reg     <= xsum_next;
            error_reg    <= error_next;
`endif
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_chain_loader
//
// Drives two loaders (40-bit chain of 8-bit words, 10-bit chain of 4-bit
// words) through a shared stimulus path selected by 'sel'. The expected chain
// bit i is bit (i mod W) of word (i div W). Latency is
// CHAIN_LEN + NWORDS + 1 plus any stall cycles (plus one with CFG_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic       st, ab, sv;
    logic [7:0] sd;

    logic sr0, en0, bit0, lat0, busy0, done0, err0;
    logic sr1, en1, bit1, lat1, busy1, done1, err1;

    cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st & ~sel), .abort(ab & ~sel),
        .s_valid(sv & ~sel), .s_ready(sr0), .s_data(sd),
        .cfg_en(en0), .cfg_bit(bit0), .cfg_latch(lat0),
        .busy(busy0), .done(done0), .error(err0)
    );

    cfg_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st & sel), .abort(ab & sel),
        .s_valid(sv & sel), .s_ready(sr1), .s_data(sd[3:0]),
        .cfg_en(en1), .cfg_bit(bit1), .cfg_latch(lat1),
        .busy(busy1), .done(done1), .error(err1)
    );

    logic o_sr, o_en, o_bit, o_lat, o_busy, o_done, o_err;
    assign o_sr   = sel ? sr1   : sr0;
    assign o_en   = sel ? en1   : en0;
    assign o_bit  = sel ? bit1  : bit0;
    assign o_lat  = sel ? lat1  : lat0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_err  = sel ? err1  : err0;

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus description for run_load
    logic [7:0] wq[$];
    int         stall_at, stall_n, abort_at;
    bit         poke_start, bad_cks;
    logic [7:0] bad_val;

    // Observations from run_load
    logic obits[$];
    int   en_cnt, latch_cnt, lat_cyc, done_cyc, err_cyc, overlap;
    int   stall_bad, stall_rdy_bad, timed_out;
    logic busy_after_abort, done_after_abort;

    // ---------------- reference model ----------------
    function automatic int cur_len();
        return sel ? 10 : 40;
    endfunction

    function automatic int cur_w();
        return sel ? 4 : 8;
    endfunction

    function automatic int cur_nwords();
        return (cur_len() + cur_w() - 1) / cur_w();
    endfunction

    function automatic logic exp_bit(input int i);
        logic [7:0] w;
        w = wq[i / cur_w()];
        return w[i % cur_w()];
    endfunction

    function automatic int exp_done_cyc();
        int n;
        n = cur_len() + cur_nwords() + 1 + stall_n;
`ifdef CFG_CHECK_EN
        n = n + 1;
`endif
        return n;
    endfunction

    task automatic clear_opts();
        stall_at = -1; stall_n = 0; abort_at = 0;
        poke_start = 0; bad_cks = 0; bad_val = 8'h00;
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        repeat (n) wq.push_back(8'($urandom));
    endtask

    // ---------------- stimulus driver ----------------
    // Issues start, then streams wq (plus checksum) while recording outputs.
    // Cycle 0 is sampled 1ns after the edge that samples start.
    task automatic run_load();
        int         wi, stall_left, abort_cyc, nw;
        bit         ended;
        logic [7:0] cks;
        nw = wq.size();
        cks = 8'h00;
        foreach (wq[i]) cks = cks ^ wq[i];
        if (bad_cks) cks = bad_val;
        obits.delete();
        en_cnt = 0; latch_cnt = 0; lat_cyc = -1; done_cyc = -1; err_cyc = -1;
        overlap = 0; stall_bad = 0; stall_rdy_bad = 0; timed_out = 0;
        busy_after_abort = 1'bx; done_after_abort = 1'bx;
        wi = 0; stall_left = stall_n; abort_cyc = -1; ended = 0;
        @(posedge clk); #1;
        st = 1'b1; ab = 1'b0; sv = 1'b0;
        @(posedge clk); #1;
        st = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (o_en) begin
                obits.push_back(o_bit);
                en_cnt++;
            end
            if (o_lat) begin
                latch_cnt++;
                if (lat_cyc < 0) lat_cyc = cyc;
            end
            if (o_en && o_lat) overlap++;
            if (o_done && done_cyc < 0) done_cyc = cyc;
            if (o_err && err_cyc < 0) err_cyc = cyc;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                busy_after_abort = o_busy;
                done_after_abort = o_done;
            end
            if (done_cyc >= 0 || err_cyc >= 0 || (abort_cyc >= 0 && cyc >= abort_cyc + 8)) begin
                ended = 1;
                break;
            end
            ab = 1'b0;
            if (abort_at > 0 && abort_cyc < 0 && o_en && en_cnt == abort_at) begin
                ab = 1'b1;
                abort_cyc = cyc;
            end
            st = poke_start && o_busy && ($urandom_range(0, 3) == 0);
            if (abort_cyc >= 0) begin
                sv = 1'b0;
            end else if (stall_left > 0 && wi == stall_at && (o_sr || stall_left < stall_n)) begin
                sv = 1'b0;
                if (!o_sr) stall_rdy_bad++;
                if (o_en) stall_bad++;
                stall_left--;
            end else begin
                sv = 1'b1;
                sd = (wi < nw) ? wq[wi] : cks;
            end
            #1;
            if (sv && o_sr) wi++;
        end
        if (!ended) timed_out = 1;
        st = 1'b0; sv = 1'b0; ab = 1'b0;
        $display("load dut%0d words=%0d stall=%0d shifts=%0d latch@%0d done@%0d err@%0d",
                 sel, nw, stall_n, en_cnt, lat_cyc, done_cyc, err_cyc);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b0; st = 1'b0; ab = 1'b0; sv = 1'b0; sd = 8'h00;
        clear_opts();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({sr0, en0, bit0, lat0, busy0, done0, err0} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_dut0 got %b expected 0000000", {sr0, en0, bit0, lat0, busy0, done0, err0});
        end
        vectors++;
        if ({sr1, en1, bit1, lat1, busy1, done1, err1} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_dut1 got %b expected 0000000", {sr1, en1, bit1, lat1, busy1, done1, err1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({sr0, busy0, done0} !== 3'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got %b expected 000", {sr0, busy0, done0});
        end
    endtask

    task automatic test_basic();
        logic [7:0] init [5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5};
        sel = 1'b0;
        clear_opts();
        wq.delete();
        foreach (init[i]) wq.push_back(init[i]);
        run_load();
        vectors++;
        if (timed_out != 0) begin miscompares++; $display("FAIL basic_timeout got %0d expected 0", timed_out); end
        vectors++;
        if (obits.size() != 40) begin miscompares++; $display("FAIL basic_bitcount got %0d expected 40", obits.size()); end
        for (int i = 0; i < 40 && i < obits.size(); i++) begin
            vectors++;
            if (obits[i] !== exp_bit(i)) begin
                miscompares++;
                $display("FAIL basic_bit[%0d] got %b expected %b", i, obits[i], exp_bit(i));
            end
        end
        vectors++;
        if (latch_cnt != 1) begin miscompares++; $display("FAIL basic_latch_count got %0d expected 1", latch_cnt); end
        vectors++;
        if (lat_cyc != exp_done_cyc() - 1) begin miscompares++; $display("FAIL basic_latch_cycle got %0d expected %0d", lat_cyc, exp_done_cyc() - 1); end
        vectors++;
        if (done_cyc != exp_done_cyc()) begin miscompares++; $display("FAIL basic_done_cycle got %0d expected %0d", done_cyc, exp_done_cyc()); end
        vectors++;
        if (overlap != 0) begin miscompares++; $display("FAIL basic_en_latch_overlap got %0d expected 0", overlap); end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({o_done, o_busy, o_lat} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_done_held got %b expected 100", {o_done, o_busy, o_lat});
        end
    endtask

    task automatic test_short_chain();
        logic [7:0] init [3] = '{8'h0F, 8'h03, 8'h0E};
        sel = 1'b1;
        clear_opts();
        wq.delete();
        foreach (init[i]) wq.push_back(init[i]);
        run_load();
        vectors++;
        if (en_cnt != 10) begin miscompares++; $display("FAIL short_shift_count got %0d expected 10", en_cnt); end
        for (int i = 0; i < 10 && i < obits.size(); i++) begin
            vectors++;
            if (obits[i] !== exp_bit(i)) begin
                miscompares++;
                $display("FAIL short_bit[%0d] got %b expected %b", i, obits[i], exp_bit(i));
            end
        end
        vectors++;
        if (latch_cnt != 1 || done_cyc != exp_done_cyc()) begin
            miscompares++;
            $display("FAIL short_commit got latch=%0d done@%0d expected latch=1 done@%0d",
                     latch_cnt, done_cyc, exp_done_cyc());
        end
    endtask

    task automatic test_stall();
        logic [7:0] init [5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5};
        sel = 1'b0;
        clear_opts();
        stall_at = 2; stall_n = 5;
        wq.delete();
        foreach (init[i]) wq.push_back(init[i]);
        run_load();
        vectors++;
        if (stall_rdy_bad != 0 || stall_bad != 0) begin
            miscompares++;
            $display("FAIL stall_fetch got ready_low=%0d en_high=%0d expected 0/0", stall_rdy_bad, stall_bad);
        end
        vectors++;
        if (obits.size() != 40) begin miscompares++; $display("FAIL stall_bitcount got %0d expected 40", obits.size()); end
        for (int i = 0; i < 40 && i < obits.size(); i++) begin
            vectors++;
            if (obits[i] !== exp_bit(i)) begin
                miscompares++;
                $display("FAIL stall_bit[%0d] got %b expected %b", i, obits[i], exp_bit(i));
            end
        end
        vectors++;
        if (done_cyc != exp_done_cyc()) begin miscompares++; $display("FAIL stall_latency got %0d expected %0d", done_cyc, exp_done_cyc()); end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        clear_opts();
        abort_at = 20;
        fill_random(5);
        run_load();
        vectors++;
        if (timed_out != 0 || en_cnt != 20) begin
            miscompares++;
            $display("FAIL abort_shift_count got %0d (timeout %0d) expected 20", en_cnt, timed_out);
        end
        vectors++;
        if ({busy_after_abort, done_after_abort} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_idle got busy/done=%b expected 00", {busy_after_abort, done_after_abort});
        end
        vectors++;
        if (latch_cnt != 0) begin miscompares++; $display("FAIL abort_no_latch got %0d expected 0", latch_cnt); end

        // abort in FETCH masks s_ready and drops the load
        @(posedge clk); #1; st = 1'b1;
        @(posedge clk); #1; st = 1'b0; ab = 1'b1; sv = 1'b1; sd = 8'($urandom);
        #1;
        vectors++;
        if (o_sr !== 1'b0) begin miscompares++; $display("FAIL abort_masks_ready got %b expected 0", o_sr); end
        @(posedge clk); #1;
        ab = 1'b0; sv = 1'b0;
        vectors++;
        if ({o_busy, o_en, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_in_fetch got %b expected 000", {o_busy, o_en, o_done});
        end

        clear_opts();
        fill_random(5);
        run_load();
        vectors++;
        if (obits.size() != 40 || done_cyc != exp_done_cyc() || latch_cnt != 1) begin
            miscompares++;
            $display("FAIL abort_reload got bits=%0d done@%0d latch=%0d expected 40 %0d 1",
                     obits.size(), done_cyc, latch_cnt, exp_done_cyc());
        end
        for (int i = 0; i < 40 && i < obits.size(); i++) begin
            vectors++;
            if (obits[i] !== exp_bit(i)) begin
                miscompares++;
                $display("FAIL abort_reload_bit[%0d] got %b expected %b", i, obits[i], exp_bit(i));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        clear_opts();
        @(posedge clk); #1; st = 1'b1;
        @(posedge clk); #1; st = 1'b0; sv = 1'b1; sd = 8'($urandom);
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ({o_en, o_busy} !== 2'b11) begin miscompares++; $display("FAIL midreset_shifting got %b expected 11", {o_en, o_busy}); end
        #2; rst_n = 1'b0;
        #1;
        vectors++;
        if ({sr0, en0, bit0, lat0, busy0, done0, err0} !== 7'b0) begin
            miscompares++;
            $display("FAIL midreset_async got %b expected 0000000", {sr0, en0, bit0, lat0, busy0, done0, err0});
        end
        sv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        poke_start = 1;
        fill_random(5);
        run_load();
        vectors++;
        if (en_cnt != 40 || done_cyc != exp_done_cyc() || latch_cnt != 1) begin
            miscompares++;
            $display("FAIL midreset_reload got bits=%0d done@%0d latch=%0d expected 40 %0d 1",
                     en_cnt, done_cyc, latch_cnt, exp_done_cyc());
        end
        for (int i = 0; i < 40 && i < obits.size(); i++) begin
            vectors++;
            if (obits[i] !== exp_bit(i)) begin
                miscompares++;
                $display("FAIL midreset_bit[%0d] got %b expected %b", i, obits[i], exp_bit(i));
            end
        end
    endtask

    task automatic test_checksum();
        logic [7:0] init [5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5};
        sel = 1'b0;
        clear_opts();
        wq.delete();
        foreach (init[i]) wq.push_back(init[i]);
`ifdef CFG_CHECK_EN
        bad_cks = 1; bad_val = 8'hDB;
        run_load();
        vectors++;
        if (latch_cnt != 1 || done_cyc != 47 || err_cyc != -1) begin
            miscompares++;
            $display("FAIL cks_good got latch=%0d done@%0d err@%0d expected 1 47 -1", latch_cnt, done_cyc, err_cyc);
        end
        bad_val = 8'h00;
        run_load();
        vectors++;
        if (err_cyc != 46 || latch_cnt != 0 || done_cyc != -1) begin
            miscompares++;
            $display("FAIL cks_bad got err@%0d latch=%0d done@%0d expected 46 0 -1", err_cyc, latch_cnt, done_cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({o_err, o_done, o_busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL cks_error_held got %b expected 100", {o_err, o_done, o_busy});
        end
        bad_cks = 0;
        run_load();
        vectors++;
        if (err_cyc != -1 || done_cyc != 47) begin
            miscompares++;
            $display("FAIL cks_error_cleared got err@%0d done@%0d expected -1 47", err_cyc, done_cyc);
        end
`else
        run_load();
        vectors++;
        if (err_cyc != -1 || o_err !== 1'b0 || done_cyc != 46) begin
            miscompares++;
            $display("FAIL error_tied got err@%0d err=%b done@%0d expected -1 0 46", err_cyc, o_err, done_cyc);
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            sel = 1'($urandom_range(0, 1));
            clear_opts();
            fill_random(cur_nwords());
            if ($urandom_range(0, 1) == 1) begin
                stall_at = $urandom_range(0, cur_nwords() - 1);
                stall_n  = $urandom_range(1, 6);
            end
            poke_start = 1'($urandom_range(0, 1));
            run_load();
            vectors++;
            if (obits.size() != cur_len() || done_cyc != exp_done_cyc() ||
                latch_cnt != 1 || err_cyc != -1 || overlap != 0) begin
                miscompares++;
                $display("FAIL rand%0d_summary got bits=%0d done@%0d latch=%0d err@%0d ovl=%0d expected %0d %0d 1 -1 0",
                         k, obits.size(), done_cyc, latch_cnt, err_cyc, overlap, cur_len(), exp_done_cyc());
            end
            for (int i = 0; i < cur_len() && i < obits.size(); i++) begin
                vectors++;
                if (obits[i] !== exp_bit(i)) begin
                    miscompares++;
                    $display("FAIL rand%0d_bit[%0d] got %b expected %b", k, i, obits[i], exp_bit(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_chain();
        test_stall();
        test_abort();
        test_reset_mid_load();
        test_checksum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequences the fabric's configuration scan chain. That chain is built from the 4-bit selector registers of the routing multiplexers, e.g. 10 IO-to-IO muxes giving 40 bits.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain.
- Pulses a commit strobe once the whole chain is loaded. The muxes only see a new selection after that commit, never a partially shifted one.
- Sits between the bitstream source (host interface / ROM reader) and the tile config chain.

Parameters:
- CHAIN_LEN, 40, total config bits in the chain (>=1).
- WORD_W, 8, width of one input config word (>=2).
- NWORDS, derived = ceil(CHAIN_LEN/WORD_W), words consumed per load (localparam, not overridable).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load; sampled in IDLE or DONE only
- abort  in  1  synchronous cancel; return to IDLE without commit
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts word this cycle
- s_data  in  WORD_W  config word, bit 0 shifted first
- cfg_en  out  1  chain shift enable
- cfg_bit  out  1  serial data into chain, valid when cfg_en=1
- cfg_latch  out  1  one-cycle commit pulse to mux selector shadow regs
- busy  out  1  load in progress (FETCH/SHIFT/LATCH)
- done  out  1  last load committed; held until next start
- error  out  1  checksum failure (only with CFG_CHECK_EN; else tied 0)

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; word counter, bit counter and shift register cleared.
- States: IDLE, FETCH, SHIFT, LATCH, DONE.
- IDLE:
  - s_ready=0.
  - start=1 moves to FETCH next cycle, clears counters and clears done and error.
- FETCH:
  - s_ready=1.
  - On s_valid&&s_ready, capture s_data into the shift register and go to SHIFT.
  - s_valid=0 means stay, with no timeout.
- SHIFT:
  - Each cycle: cfg_en=1, cfg_bit=sreg[0], sreg shifts right, bit_in_word++, total_bits++.
  - s_ready=0.
  - Word bit limit: if this is word NWORDS-1, the limit is CHAIN_LEN-(NWORDS-1)*WORD_W. Otherwise it is WORD_W.
  - On the cycle the limit-th bit is emitted: go to LATCH if total_bits reaches CHAIN_LEN, else go to FETCH.
  - Unused upper bits of the final word are discarded and never shifted.
- LATCH:
  - cfg_latch=1 for exactly one cycle, cfg_en=0, then go to DONE.
- DONE:
  - done=1.
  - start=1 restarts at FETCH (done clears that cycle). Otherwise stay.
- busy is 1 in FETCH, SHIFT and LATCH.
- Latency: with s_valid held high, a full load takes CHAIN_LEN + NWORDS + 1 cycles from the start-sample edge to the edge entering DONE.
  - Example, CHAIN_LEN=40, WORD_W=8: 46 cycles.
- cfg_en and cfg_latch are never high in the same cycle.
- start in FETCH, SHIFT or LATCH is ignored.
- abort:
  - In any state other than IDLE: next state IDLE, no cfg_latch, done=0, counters cleared.
  - abort takes priority over start and over a simultaneous handshake; that word is not consumed, so s_ready=0 when abort=1.
  - The chain may hold partial data, but the muxes keep the old committed config.
- Reset mid-load: same effect as abort, applied immediately and asynchronously.
- Counters are sized $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1). No wrap is possible within one load.

Optional Feature:
- Macro: CFG_CHECK_EN.
- When defined:
  - After the NWORDS payload words, FETCH accepts one extra checksum word; this word is not shifted.
  - The expected checksum is the XOR of all payload words, with the final word's unused upper bits included as supplied.
  - On a match: go to LATCH as normal.
  - On a mismatch: no cfg_latch, error=1, go to DONE with done=0.
  - error holds until the next start.
  - Latency grows by 1 cycle.
- When undefined: no checksum word, error is constant 0, and the checksum logic is absent.

Test Plan:
1. CHAIN_LEN=40, WORD_W=8, words 0x01,0x80,0xFF,0x00,0xA5 streamed back-to-back:
   - cfg_bit sequence is 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1, then 8x1, 8x0, then 1,0,1,0,0,1,0,1.
   - cfg_en is high for 40 cycles total.
   - cfg_latch pulses once, 45 cycles after the start edge; done=1 the following cycle.
2. CHAIN_LEN=10, WORD_W=4, words 0xF,0x3,0xE:
   - Exactly 10 shift cycles.
   - The final word emits only bits 0,1 (0,1); bits 2,3 are never driven.
   - Commit occurs and done=1.
3. s_valid withheld for 5 cycles between words 2 and 3:
   - s_ready stays 1 in FETCH and cfg_en stays 0 during the stall.
   - The bit stream is identical to scenario 1; latency is +5.
4. abort asserted on the 20th SHIFT cycle:
   - Next cycle state is IDLE, busy=0, done=0, no cfg_latch ever pulses.
   - A following start performs a clean full load.
5. rst_n dropped during SHIFT:
   - All outputs go to 0 asynchronously, before the next clk edge.
   - After release, start gives a normal load. start pulses while busy cause no restart and the bit count stays 40.
6. CFG_CHECK_EN, scenario-1 words:
   - Checksum word 0xDB (the XOR of the five words) gives cfg_latch and done=1.
   - Checksum word 0x00 gives error=1, done=0 and no cfg_latch.
